// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - MMIO offsets, STATUS bit positions and address decode classes
package mem_map_pkg;

  localparam logic [7:0] OFF_TXDATA = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h01;
  localparam logic [7:0] OFF_CYCLE0 = 8'h04;
  localparam logic [7:0] OFF_CYCLE1 = 8'h05;
  localparam logic [7:0] OFF_CYCLE2 = 8'h06;
  localparam logic [7:0] OFF_CYCLE3 = 8'h07;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_BADADDR = 3;

  typedef enum logic [1:0] {
    DEC_RAM,
    DEC_MMIO,
    DEC_HOLE
  } dec_e;

  function automatic logic [7:0] status_byte(input logic badaddr, input logic ovf,
                                             input logic empty, input logic full);
    logic [7:0] s;
    s              = 8'h00;
    s[ST_FULL]     = full;
    s[ST_EMPTY]    = empty;
    s[ST_OVF]      = ovf;
    s[ST_BADADDR]  = badaddr;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - byte FIFO; a push while full is taken only if a pop frees the slot that cycle
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;

  // Head reads as zero when empty so the output is defined straight out of reset.
  assign head_data = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - zero-wait-state RAM plus MMIO (console TX FIFO, status, cycle counter)
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int          RAM_AW     = 12,
  parameter int          DATA_WIDTH = 8,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [31:0]           i_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_write,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_fault
);

  dec_e        dec;
  logic [7:0]  offset;
  logic        mmio_wr;
  logic        tx_push;
  logic        tx_pop;
  logic        tx_full;
  logic        tx_empty;
  logic        tx_overflow;
  logic        status_wr;
  logic        cycle0_rd;
  logic        ovf;
  logic        badaddr;
  logic [31:0] cycle_cnt;
  logic [23:0] cycle_latch;
  logic [7:0]  mmio_rdata;

  logic [DATA_WIDTH-1:0] ram [2**RAM_AW];

  always_comb begin
    if (i_mem_addr[31:RAM_AW] == '0)
      dec = DEC_RAM;
    else if (i_mem_addr[31:8] == MMIO_BASE[31:8])
      dec = DEC_MMIO;
    else
      dec = DEC_HOLE;
  end

  assign offset    = i_mem_addr[7:0];
  assign mmio_wr   = i_mem_write && (dec == DEC_MMIO);
  assign tx_push   = mmio_wr && (offset == OFF_TXDATA);
  assign status_wr = mmio_wr && (offset == OFF_STATUS);
  assign cycle0_rd = !i_mem_write && (dec == DEC_MMIO) && (offset == OFF_CYCLE0);
  assign tx_pop    = o_tx_valid && i_tx_ready;

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .push     (tx_push),
    .push_data(i_mem_data[7:0]),
    .pop      (tx_pop),
    .head_data(o_tx_data),
    .full     (tx_full),
    .empty    (tx_empty),
    .overflow (tx_overflow)
  );

  assign o_tx_valid = !tx_empty;
  assign o_fault    = ovf || badaddr;

  always_ff @(posedge i_clk) begin
    if (i_mem_write && (dec == DEC_RAM))
      ram[i_mem_addr[RAM_AW-1:0]] <= i_mem_data;
  end

  // Bytes 1..3 of the counter come from the latch taken on the byte-0 read,
  // so a multi-byte read sees one consistent value.
  always_comb begin
    mmio_rdata = 8'h00;
    case (offset)
      OFF_STATUS: mmio_rdata = status_byte(badaddr, ovf, tx_empty, tx_full);
      OFF_CYCLE0: mmio_rdata = cycle_cnt[7:0];
      OFF_CYCLE1: mmio_rdata = cycle_latch[7:0];
      OFF_CYCLE2: mmio_rdata = cycle_latch[15:8];
      OFF_CYCLE3: mmio_rdata = cycle_latch[23:16];
      default:    mmio_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_data <= '0;
    end else if (i_mem_write) begin
      o_mem_data <= '0;
    end else begin
      case (dec)
        DEC_RAM:  o_mem_data <= ram[i_mem_addr[RAM_AW-1:0]];
        DEC_MMIO: o_mem_data <= DATA_WIDTH'(mmio_rdata);
        default:  o_mem_data <= '0;
      endcase
    end
  end

  // Setting a flag wins over a clear; both cannot target the same access anyway.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle_cnt   <= '0;
      cycle_latch <= '0;
      ovf         <= 1'b0;
      badaddr     <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (cycle0_rd)
        cycle_latch <= cycle_cnt[31:8];
      if (tx_overflow)
        ovf <= 1'b1;
      else if (status_wr && i_mem_data[ST_OVF])
        ovf <= 1'b0;
      if (dec == DEC_HOLE)
        badaddr <= 1'b1;
      else if (status_wr && i_mem_data[ST_BADADDR])
        badaddr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

  localparam logic [31:0] A_TX     = 32'hFFFF_FF00;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FF01;
  localparam logic [31:0] A_CYC0   = 32'hFFFF_FF04;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic [7:0]  mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        fault;

  int checks = 0;
  int errors = 0;

  mem_responder dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_mem_addr (mem_addr),
    .i_mem_data (mem_wdata),
    .i_mem_write(mem_write),
    .o_mem_data (mem_rdata),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_addr  = a;
    mem_wdata = d;
    mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    mem_addr  = a;
    mem_write = 1'b0;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 8'h00;
    mem_write = 1'b0;
    tx_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", mem_rdata, 8'h00);
    check("rst_valid", tx_valid, 1'b0);
    check("rst_txdata", tx_data, 8'h00);
    check("rst_fault", fault, 1'b0);

    // Counter is 0 after release; 255 edges later it holds 0xFF.
    rst_n = 1'b1;
    repeat (255) tick();
    rd(A_CYC0);
    check("cyc_b0", mem_rdata, 8'hFF);
    rd(A_CYC0 + 32'd1);
    check("cyc_b1", mem_rdata, 8'h00);
    rd(A_CYC0 + 32'd2);
    check("cyc_b2", mem_rdata, 8'h00);
    rd(A_CYC0 + 32'd3);
    check("cyc_b3", mem_rdata, 8'h00);

    wr(32'h7BC, 8'hC0);
    check("wr_rdata_zero", mem_rdata, 8'h00);
    wr(32'h7BD, 8'h00);
    rd(32'h7BC);
    check("ram_7bc", mem_rdata, 8'hC0);
    rd(32'h7BD);
    check("ram_7bd", mem_rdata, 8'h00);

    wr(32'h0, 8'h13);
    wr(32'h1, 8'h05);
    wr(32'h2, 8'h50);
    wr(32'h3, 8'h01);
    rd(32'h0);
    check("fetch0", mem_rdata, 8'h13);
    rd(32'h1);
    check("fetch1", mem_rdata, 8'h05);
    rd(32'h2);
    check("fetch2", mem_rdata, 8'h50);
    rd(32'h3);
    check("fetch3", mem_rdata, 8'h01);

    for (int i = 0; i < 9; i++) wr(A_TX, 8'h41 + 8'(i));
    rd(A_STATUS);
    check("ovf_status", mem_rdata, 8'h05);
    check("ovf_fault", fault, 1'b1);
    rd(32'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain1_valid", tx_valid, 1'b1);
      check("drain1_data", tx_data, 8'h41 + 8'(i));
      tick();
    end
    check("drain1_empty", tx_valid, 1'b0);
    wr(A_STATUS, 8'h04);
    check("ovf_cleared", fault, 1'b0);

    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_TX, 8'h50 + 8'(i));
    rd(A_STATUS);
    check("full_status", mem_rdata, 8'h01);
    tx_ready = 1'b1;
    wr(A_TX, 8'h5A);
    tx_ready = 1'b0;
    rd(A_STATUS);
    check("pushpop_status", mem_rdata, 8'h01);
    check("pushpop_fault", fault, 1'b0);
    rd(32'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain2_data", tx_data, (i == 7) ? 8'h5A : 8'h51 + 8'(i));
      tick();
    end
    check("drain2_empty", tx_valid, 1'b0);
    tx_ready = 1'b0;

    rd(32'h7BC);
    check("pre_hole_rdata", mem_rdata, 8'hC0);
    rd(32'h1000);
    check("hole_rdata", mem_rdata, 8'h00);
    check("hole_fault", fault, 1'b1);
    rd(A_STATUS);
    check("hole_status", mem_rdata, 8'h0A);

    wr(A_TX, 8'h77);
    rd(32'h7BC);
    check("pre_rst_valid", tx_valid, 1'b1);
    check("pre_rst_rdata", mem_rdata, 8'hC0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", tx_valid, 1'b0);
    check("async_rst_rdata", mem_rdata, 8'h00);
    check("async_rst_txdata", tx_data, 8'h00);
    check("async_rst_fault", fault, 1'b0);
    tick();
    rst_n = 1'b1;
    rd(32'h7BC);
    check("ram_kept", mem_rdata, 8'hC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
